// File: rtl/ether_rx_packer.sv
// RMII receive front end: hunts for preamble/SFD, packs payload dibits into
// OUT_WIDTH-bit words, flushes a zero-padded partial word and reports frame length.
module ether_rx_packer #(
  parameter int OUT_WIDTH    = 8,
  parameter int MIN_PREAMBLE = 8,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   crsdv,
  input  logic [1:0]             rxd,
  output logic                   axiov,
  output logic [OUT_WIDTH-1:0]   axiod,
  output logic                   axio_partial,
  output logic                   preamble_err,
  output logic                   frame_done,
  output logic [COUNT_WIDTH-1:0] frame_dibits
);
  localparam int SLOTS = OUT_WIDTH / 2;
  localparam int KW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int PW    = $clog2(MIN_PREAMBLE + 1);
  localparam logic [KW-1:0] K_LAST = KW'(SLOTS - 1);
  localparam logic [PW-1:0] P_MIN  = PW'(MIN_PREAMBLE);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          pre_cnt_q, pre_cnt_d;
  logic [KW-1:0]          k_q, k_d;
  logic [OUT_WIDTH-1:0]   pack_q, pack_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   axiov_q, axiov_d;
  logic [OUT_WIDTH-1:0]   axiod_q, axiod_d;
  logic                   axio_partial_q, axio_partial_d;
  logic                   preamble_err_q, preamble_err_d;
  logic                   frame_done_q, frame_done_d;
  logic [COUNT_WIDTH-1:0] frame_dibits_q, frame_dibits_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pre_cnt_q      <= '0;
      k_q            <= '0;
      pack_q         <= '0;
      cnt_q          <= '0;
      axiov_q        <= 1'b0;
      axiod_q        <= '0;
      axio_partial_q <= 1'b0;
      preamble_err_q <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_dibits_q <= '0;
    end else begin
      state_q        <= state_d;
      pre_cnt_q      <= pre_cnt_d;
      k_q            <= k_d;
      pack_q         <= pack_d;
      cnt_q          <= cnt_d;
      axiov_q        <= axiov_d;
      axiod_q        <= axiod_d;
      axio_partial_q <= axio_partial_d;
      preamble_err_q <= preamble_err_d;
      frame_done_q   <= frame_done_d;
      frame_dibits_q <= frame_dibits_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pre_cnt_d      = pre_cnt_q;
    k_d            = k_q;
    pack_d         = pack_q;
    cnt_d          = cnt_q;
    axiov_d        = 1'b0;
    axiod_d        = axiod_q;
    axio_partial_d = 1'b0;
    preamble_err_d = 1'b0;
    frame_done_d   = 1'b0;
    frame_dibits_d = frame_dibits_q;
    case (state_q)
      IDLE: begin
        if (crsdv && rxd == 2'b10) begin
          state_d   = PREAMBLE;
          pre_cnt_d = PW'(1);
        end
      end
      PREAMBLE: begin
        if (!crsdv) begin
          state_d = IDLE;
        end else if (rxd == 2'b10) begin
          if (pre_cnt_q < P_MIN) pre_cnt_d = pre_cnt_q + 1'b1;
        end else if (rxd == 2'b11 && pre_cnt_q >= P_MIN) begin
          state_d = DATA;
          k_d     = '0;
          pack_d  = '0;
          cnt_d   = '0;
        end else begin
          preamble_err_d = 1'b1;
          state_d        = DROP;
        end
      end
      DATA: begin
        if (crsdv) begin
          pack_d[2*int'(k_q) +: 2] = rxd;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (k_q == K_LAST) begin
            axiov_d = 1'b1;
            axiod_d = pack_d;
            pack_d  = '0;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end else begin
          // Pending slots are already zero because the packer is cleared on every emit.
          frame_done_d   = 1'b1;
          frame_dibits_d = cnt_q;
          state_d        = IDLE;
          if (k_q != '0) begin
            axiov_d        = 1'b1;
            axio_partial_d = 1'b1;
            axiod_d        = pack_q;
          end
          k_d    = '0;
          pack_d = '0;
        end
      end
      DROP: begin
        if (!crsdv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign axiov        = axiov_q;
  assign axiod        = axiod_q;
  assign axio_partial = axio_partial_q;
  assign preamble_err = preamble_err_q;
  assign frame_done   = frame_done_q;
  assign frame_dibits = frame_dibits_q;
endmodule

// File: tb/tb_ether_rx_packer.sv
// Bench for ether_rx_packer: three widths driven in parallel, each frame's output
// compared against word lists computed from the frame's preamble and payload.
module tb_ether_rx_packer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic crsdv = 1'b0;
  logic [1:0] rxd = 2'b00;

  always #5 clk = ~clk;

  logic        ov[3], op[3], pe[3], fd[3];
  logic [31:0] od[3];
  logic [15:0] fdib[3];
  logic [7:0]  od8;
  logic [1:0]  od2;
  logic [5:0]  od6;
  logic [15:0] fd8, fd2;
  logic [3:0]  fd6;

  ether_rx_packer #(.OUT_WIDTH(8), .MIN_PREAMBLE(8), .COUNT_WIDTH(16)) u8 (
    .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd), .axiov(ov[0]), .axiod(od8),
    .axio_partial(op[0]), .preamble_err(pe[0]), .frame_done(fd[0]), .frame_dibits(fd8));
  ether_rx_packer #(.OUT_WIDTH(2), .MIN_PREAMBLE(8), .COUNT_WIDTH(16)) u2 (
    .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd), .axiov(ov[1]), .axiod(od2),
    .axio_partial(op[1]), .preamble_err(pe[1]), .frame_done(fd[1]), .frame_dibits(fd2));
  ether_rx_packer #(.OUT_WIDTH(6), .MIN_PREAMBLE(8), .COUNT_WIDTH(4)) u6 (
    .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd), .axiov(ov[2]), .axiod(od6),
    .axio_partial(op[2]), .preamble_err(pe[2]), .frame_done(fd[2]), .frame_dibits(fd6));

  assign od[0]   = {24'b0, od8};
  assign od[1]   = {30'b0, od2};
  assign od[2]   = {26'b0, od6};
  assign fdib[0] = fd8;
  assign fdib[1] = fd2;
  assign fdib[2] = {12'b0, fd6};

  int W_OF[3] = '{8, 2, 6};
  int CMAX[3] = '{65535, 65535, 15};

  logic [32:0] got_w[3][$];
  int          got_fd[3][$];
  bit          got_fp[3][$];
  int          got_err[3];
  int          n_chk = 0;
  int          n_pass = 0;

  // Event recorder: words carry the partial flag in bit 32.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ov[i]) got_w[i].push_back({op[i], od[i]});
      if (fd[i]) begin
        got_fd[i].push_back(int'(fdib[i]));
        got_fp[i].push_back(ov[i] & op[i]);
      end
      if (pe[i]) got_err[i]++;
    end
  end

  task automatic check(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s (OUT_WIDTH=%0d) observed %0h expected %0h", tag, W_OF[i], obs, exp);
  endtask

  task automatic step(input logic c, input logic [1:0] d);
    crsdv = c;
    rxd   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    for (int i = 0; i < 3; i++) begin
      got_w[i].delete();
      got_fd[i].delete();
      got_fp[i].delete();
      got_err[i] = 0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_axiov"}, i, 64'(ov[i]), 64'd0);
      check({tag, "_axiod"}, i, 64'(od[i]), 64'd0);
      check({tag, "_partial"}, i, 64'(op[i]), 64'd0);
      check({tag, "_perr"}, i, 64'(pe[i]), 64'd0);
      check({tag, "_fdone"}, i, 64'(fd[i]), 64'd0);
      check({tag, "_fdibits"}, i, 64'(fdib[i]), 64'd0);
    end
  endtask

  // ptype: 0 = preamble then SFD, 1 = preamble abandoned by carrier drop, 2 = corrupt dibit 00
  // pat: 0 random, 1 repeating 11,01,01, 2 all 01, 3 fixed 11,01,00
  task automatic run_frame(input string tag, input int npre, input int ptype, input int n, input int pat);
    logic [1:0]  pl[$];
    logic [32:0] ew[$];
    logic [32:0] w;
    bit          valid, err;
    int          s, nw;
    clear_events();
    step(1'b0, 2'b10);
    step(1'b1, 2'b11);
    step(1'b1, 2'b00);
    step(1'b1, 2'b01);
    repeat (npre) step(1'b1, 2'b10);
    if (ptype == 2) step(1'b1, 2'b00);
    for (int j = 0; j < n; j++) begin
      case (pat)
        1:       pl.push_back((j % 3 == 0) ? 2'b11 : 2'b01);
        2:       pl.push_back(2'b01);
        3:       pl.push_back((j == 0) ? 2'b11 : (j == 1) ? 2'b01 : 2'b00);
        default: pl.push_back(2'($urandom_range(0, 3)));
      endcase
    end
    if (ptype != 1) begin
      step(1'b1, 2'b11);
      foreach (pl[j]) step(1'b1, pl[j]);
    end
    repeat (3) step(1'b0, 2'($urandom_range(0, 3)));

    valid = (ptype == 0) && (npre >= 8);
    err   = (ptype == 2) || (ptype == 0 && npre < 8);
    for (int i = 0; i < 3; i++) begin
      s = W_OF[i] / 2;
      ew.delete();
      if (valid) begin
        for (int g = 0; g < n; g += s) begin
          w = '0;
          for (int j = 0; j < s && g + j < n; j++) w |= 33'(pl[g+j]) << (2 * j);
          if (n - g < s) w[32] = 1'b1;
          ew.push_back(w);
        end
      end
      check({tag, "_nwords"}, i, 64'(got_w[i].size()), 64'(ew.size()));
      nw = (got_w[i].size() < ew.size()) ? got_w[i].size() : ew.size();
      for (int k = 0; k < nw; k++) check({tag, "_word"}, i, 64'(got_w[i][k]), 64'(ew[k]));
      check({tag, "_nframes"}, i, 64'(got_fd[i].size()), valid ? 64'd1 : 64'd0);
      if (valid && got_fd[i].size() > 0) begin
        check({tag, "_fdibits"}, i, 64'(got_fd[i][0]), 64'((n > CMAX[i]) ? CMAX[i] : n));
        check({tag, "_flush_with_done"}, i, 64'(got_fp[i][0]), 64'((n % s) != 0));
      end
      check({tag, "_perr_cnt"}, i, 64'(got_err[i]), err ? 64'd1 : 64'd0);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check_outputs_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    run_frame("long_pattern", 31, 0, 6040, 1);
    run_frame("six_01", 8, 0, 6, 2);
    run_frame("short_pre", 4, 0, 20, 0);
    run_frame("resume", 8, 0, 20, 0);
    run_frame("corrupt", 3, 2, 10, 0);
    run_frame("pre_seven", 7, 0, 5, 0);
    run_frame("pre_abort", 10, 1, 0, 0);
    run_frame("empty", 9, 0, 0, 0);
    run_frame("dibit_passthru", 8, 0, 3, 3);
    for (int r = 0; r < 6; r++)
      run_frame("random", $urandom_range(6, 12), 0, $urandom_range(0, 40), 0);

    // Reset in the middle of a frame's payload, carrier left high afterwards.
    clear_events();
    repeat (8) step(1'b1, 2'b10);
    step(1'b1, 2'b11);
    repeat (10) step(1'b1, 2'($urandom_range(0, 3)));
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_rst");
    clear_events();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      case ($urandom_range(0, 2))
        0:       step(1'b1, 2'b00);
        1:       step(1'b1, 2'b01);
        default: step(1'b1, 2'b11);
      endcase
    end
    repeat (3) step(1'b0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      check("post_rst_words", i, 64'(got_w[i].size()), 64'd0);
      check("post_rst_frames", i, 64'(got_fd[i].size()), 64'd0);
      check("post_rst_perr", i, 64'(got_err[i]), 64'd0);
    end
    run_frame("after_rst", 8, 0, 12, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ether_rx_packer.md
Name: ether_rx_packer

Overview:
- Parametrised successor to the team's RMII receive front end `ether`.
- Takes 2-bit RMII dibits (crsdv/rxd) from the PHY and hunts for a valid preamble/SFD.
- Packs payload dibits into OUT_WIDTH-bit words on a valid strobe for downstream FCS check and byte sinks.
- Adds behaviour `ether` lacks: minimum-preamble check with error flag, zero-padded partial-word flush, end-of-frame pulse with dibit length.

Parameters:
OUT_WIDTH, 8, output word width in bits; even, 2..32; OUT_WIDTH=2 is dibit pass-through.
MIN_PREAMBLE, 8, minimum number of preamble dibits (2'b10) required before SFD dibit 2'b11.
COUNT_WIDTH, 16, width of frame dibit-length counter.

Ports:
clk  in  1  system clock, one dibit sampled per rising edge.
rst  in  1  asynchronous, active-high reset.
crsdv  in  1  RMII carrier sense / data valid.
rxd  in  2  RMII receive dibit.
axiov  out  1  one-cycle strobe: axiod holds a packed word.
axiod  out  OUT_WIDTH  packed payload word; first-received dibit in [1:0], next in [3:2], etc.
axio_partial  out  1  high with axiov when the word is a zero-padded flush.
preamble_err  out  1  one-cycle pulse: preamble too short or corrupted.
frame_done  out  1  one-cycle pulse at end of a payload frame.
frame_dibits  out  COUNT_WIDTH  payload dibit count of the finished frame; valid while frame_done=1, held otherwise.

Behaviour:
- Reset (async, any state): state=IDLE; axiov, axiod, axio_partial, preamble_err, frame_done, frame_dibits, all internal counters = 0.
- All outputs registered. A word is presented on the clk edge that samples its last dibit; axiov is high for exactly that following cycle.
- State machine: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - crsdv=1 and rxd=2'b10: go to PREAMBLE, pre_cnt=1.
  - Any other dibit: ignored, stay IDLE. Leading line noise is discarded silently.
- PREAMBLE:
  - crsdv=0: go to IDLE, no error.
  - rxd=2'b10: pre_cnt++, saturating at MIN_PREAMBLE.
  - rxd=2'b11 with pre_cnt>=MIN_PREAMBLE: go to DATA; clear packer and dibit counter.
  - rxd=2'b11 with pre_cnt<MIN_PREAMBLE, or rxd=2'b00/2'b01: pulse preamble_err, go to DROP.
- DATA, crsdv=1:
  - Shift rxd into packer slot k = dibit index mod (OUT_WIDTH/2); increment dibit counter, saturating at all-ones.
  - When slot OUT_WIDTH/2-1 fills: axiov=1, axiod=packed word, axio_partial=0.
- DATA, crsdv=0 (end of carrier):
  - frame_done=1 and frame_dibits=counter on the same edge; go to IDLE.
  - If k>0 dibits are pending, on the same edge: axiov=1, axio_partial=1, axiod=pending dibits in low slots, upper slots 0.
  - If k=0: no extra word.
- DROP: ignore all dibits until crsdv=0, then go to IDLE. No axiov, frame_done or preamble_err while in DROP.
- Empty payload (SFD then immediate crsdv=0): frame_done=1, frame_dibits=0, no axiov.
- OUT_WIDTH=2: every payload dibit gives axiov; axio_partial is never set.
- crsdv is not debounced. In DATA, a single low cycle ends the frame.
- Reset mid-frame:
  - All outputs drop to 0 asynchronously; no frame_done or flush is generated.
  - After reset release the block is in IDLE. If crsdv is still high, remaining dibits are ignored until a fresh 2'b10 appears.

Test Plan:
1. OUT_WIDTH=8, MIN_PREAMBLE=8: dibits 11,00,01, then 31×10, then 11, then 6040 payload dibits repeating 11,01,01, then crsdv=0.
   -> 1510 axiov strobes cycling 0xD7,0x75,0x5D; axio_partial never set.
   -> frame_done once with frame_dibits=6040; preamble_err never asserted.
2. OUT_WIDTH=8: valid preamble+SFD, then 6 dibits of 01, then crsdv=0.
   -> axiod=0x55 with axio_partial=0.
   -> then axiod=0x05 with axio_partial=1 on the same cycle as frame_done, frame_dibits=6.
3. MIN_PREAMBLE=8: 4×10 then 11 then 20 payload dibits.
   -> preamble_err one cycle after the SFD edge; zero axiov; no frame_done.
   -> After crsdv=0 and a valid frame, normal output resumes.
4. Preamble 10,10,10,00 (corrupt) -> preamble_err pulse, DROP; stays silent until crsdv falls.
5. OUT_WIDTH=2: valid frame with payload 11,01,00 -> three axiov strobes with axiod=3,1,0, then frame_done with frame_dibits=3.
6. Assert rst asynchronously (mid-cycle) after 10 payload dibits with crsdv still high.
   -> All outputs 0 immediately; no frame_done; no output until a new preamble/SFD.
